uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and start sequencer that shares the single UART transmitter between NUM_REQ on-chip requesters. It sits between the requesters and the transmitter's Tx_Data / Transmit_Start / Tx_Busy handshake. It captures one byte per grant, drives the start handshake until the transmitter reports busy, then waits for the frame to finish before arbitrating again. A start timeout keeps a dead transmitter from hanging the arbiter.

## Interface
- DATA_BITS, 8, width of one transmit character
- NUM_REQ, 4, number of requesters (2..16)
- START_TIMEOUT, 16, SysClk cycles Transmit_Start is held waiting for Tx_Busy before abort (≥2)
- SysClk  in  1  system clock, all logic on rising edge
- Rst  in  1  reset, asynchronous, active-high
- Req_Valid  in  NUM_REQ  per-requester request, held with Req_Data until acked
- Req_Data  in  NUM_REQ*DATA_BITS  flattened data, requester i at [i*DATA_BITS +: DATA_BITS]
- Req_Ack  out  NUM_REQ  one-hot, 1-cycle pulse: requester's byte captured
- Tx_Data  out  DATA_BITS  registered byte to transmitter
- Transmit_Start  out  1  start request to transmitter
- Tx_Busy  in  1  transmitter frame in progress
- Grant_Id  out  $clog2(NUM_REQ)  index of last granted requester
- Arb_Busy  out  1  high in any state other than IDLE
- Start_Timeout  out  1  1-cycle pulse when a start attempt is aborted

## Operation
- States: IDLE, START, BUSY. Encoding is free. Reset state is IDLE.
- IDLE: arbitrates only when Tx_Busy=0 and any Req_Valid=1.
  - Search starts at Grant_Id+1 and wraps modulo NUM_REQ. The first valid requester wins.
  - On the winning edge:
    - Tx_Data<=winner's Req_Data.
    - Grant_Id<=winner.
    - Req_Ack[winner]<=1 for exactly one cycle.
    - Transmit_Start<=1.
    - Timeout counter<=0.
    - Next state START.
- START: Transmit_Start stays 1.
  - If Tx_Busy=1: Transmit_Start<=0, next state BUSY.
  - Else the counter increments. When the counter reaches START_TIMEOUT-1 with Tx_Busy still 0:
    - Transmit_Start<=0.
    - Start_Timeout pulses.
    - Next state IDLE.
    - The byte is dropped; there is no retry and no re-ack.
- BUSY: stays until Tx_Busy=0, then next state IDLE.
- Round-robin pointer: Grant_Id is updated on every grant, including grants that later time out. Reset value is NUM_REQ-1, so requester 0 has first priority after reset.
- Req_Valid changes after the ack have no effect on the transfer in flight. Requesters deassert, or present new data, the cycle after Req_Ack.
- Simultaneous requests are served one per frame in rotating order. No requester waits more than NUM_REQ-1 frames.
- Tx_Busy=1 while in IDLE (transmitter used by BIST or another path) blocks arbitration. No ack is issued.
- Reset asserted mid-operation:
  - All outputs go to their reset values immediately, asynchronously.
  - State goes to IDLE and the pointer to NUM_REQ-1.
  - The transfer in flight is abandoned.

## Timing
- Reset values:
  - Tx_Data=0, Transmit_Start=0, Req_Ack=0.
  - Grant_Id=NUM_REQ-1.
  - Arb_Busy=0, Start_Timeout=0.
- All outputs are registered. No combinational path from inputs to outputs.
- Arbitration latency: Req_Valid seen at edge N (IDLE, Tx_Busy=0) gives Req_Ack, Transmit_Start=1 and the new Tx_Data valid after edge N.
- Transmit_Start falls on the first edge after Tx_Busy is sampled 1. If Tx_Busy is already 1 at edge N+1, Transmit_Start is high for exactly 1 cycle.
- Timeout: Transmit_Start is high for exactly START_TIMEOUT cycles when Tx_Busy never rises.
- Back-to-back: Tx_Busy sampled 0 in BUSY at edge M moves the state to IDLE. The earliest next grant is edge M+1, so there is a 1-cycle IDLE gap between frames.
- Arb_Busy=1 from edge N through the edge that returns the state to IDLE.

## Test plan
- Single request: reset, then Req_Valid=4'b0001, Req_Data[0]=8'hA5, Tx_Busy model rises 2 cycles after start and stays high 20 cycles.
  - Required: one Req_Ack=4'b0001 pulse, Tx_Data=8'hA5, Grant_Id=0.
  - Required: Transmit_Start high 2 cycles, Arb_Busy falls 1 cycle after Tx_Busy falls.
- All four requesting continuously, data 8'h10..8'h13.
  - Required: grants in order 0,1,2,3,0, with acks one per frame.
  - Required: Tx_Data sequence 10,11,12,13,10.
- Timeout: Tx_Busy held 0, Req_Valid[2]=1.
  - Required: Transmit_Start high exactly 16 cycles, then one Start_Timeout pulse.
  - Required: state returns to IDLE, Grant_Id=2, next grant goes to requester 3 if it is valid.
- Blocked start: Tx_Busy=1 externally with Req_Valid[1]=1.
  - Required: no Req_Ack and Arb_Busy=0 while blocked.
  - Required: after Tx_Busy falls, grant to requester 1 on the next edge.
- Reset mid-BUSY: assert Rst while Tx_Busy=1 after a grant to requester 3.
  - Required: all outputs at reset values in the same cycle and Grant_Id=3.
  - Required: after release with Req_Valid=4'b1001, requester 0 is granted first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter and start sequencer that shares one
// UART transmitter among NUM_REQ requesters, with a start-handshake timeout.
module uart_tx_arbiter #(
    parameter  int DATA_BITS     = 8,
    parameter  int NUM_REQ       = 4,
    parameter  int START_TIMEOUT = 16,
    localparam int GW            = $clog2(NUM_REQ),
    localparam int CW            = $clog2(START_TIMEOUT)
) (
    input  logic                         SysClk,
    input  logic                         Rst,
    input  logic [NUM_REQ-1:0]           Req_Valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] Req_Data,
    output logic [NUM_REQ-1:0]           Req_Ack,
    output logic [DATA_BITS-1:0]         Tx_Data,
    output logic                         Transmit_Start,
    input  logic                         Tx_Busy,
    output logic [GW-1:0]                Grant_Id,
    output logic                         Arb_Busy,
    output logic                         Start_Timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } state_e;

    localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);
    localparam logic [GW-1:0] GID_RST  = GW'(NUM_REQ - 1);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 start_q, start_d;
    logic [GW-1:0]        gid_q, gid_d;
    logic                 busy_q, busy_d;
    logic                 tmo_q, tmo_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                 found;
    logic [GW-1:0]        win;
    int                   idx;

    // Rotating priority: search begins just after the last granted requester.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(gid_q) + k) % NUM_REQ;
            if (!found && Req_Valid[idx]) begin
                found = 1'b1;
                win   = GW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = '0;
        data_d  = data_q;
        start_d = start_q;
        gid_d   = gid_q;
        tmo_d   = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (!Tx_Busy && found) begin
                    data_d     = Req_Data[int'(win)*DATA_BITS +: DATA_BITS];
                    gid_d      = win;
                    ack_d[win] = 1'b1;
                    start_d    = 1'b1;
                    cnt_d      = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (Tx_Busy) begin
                    start_d = 1'b0;
                    state_d = BUSY;
                end else if (cnt_q == CNT_LAST) begin
                    // Dead transmitter: drop the byte, no retry.
                    start_d = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BUSY: begin
                if (!Tx_Busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                start_d = 1'b0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge SysClk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            ack_q   <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            gid_q   <= GID_RST;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            start_q <= start_d;
            gid_q   <= gid_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Req_Ack        = ack_q;
    assign Tx_Data        = data_q;
    assign Transmit_Start = start_q;
    assign Grant_Id       = gid_q;
    assign Arb_Busy       = busy_q;
    assign Start_Timeout  = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized frames against a
// transaction-level round-robin model of the UART transmit arbiter.
module tb_uart_tx_arbiter;

    localparam int DB = 8;
    localparam int NR = 4;
    localparam int ST = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [31:0]   req_data;
    logic [NR-1:0] ack;
    logic [DB-1:0] tx_data;
    logic          start;
    logic          tx_busy;
    logic [1:0]    gid;
    logic          arb;
    logic          tmo;

    int nchk = 0;
    int nerr = 0;
    int ptr_m;

    uart_tx_arbiter #(
        .DATA_BITS    (DB),
        .NUM_REQ      (NR),
        .START_TIMEOUT(ST)
    ) dut (
        .SysClk        (clk),
        .Rst           (rst),
        .Req_Valid     (req_valid),
        .Req_Data      (req_data),
        .Req_Ack       (ack),
        .Tx_Data       (tx_data),
        .Transmit_Start(start),
        .Tx_Busy       (tx_busy),
        .Grant_Id      (gid),
        .Arb_Busy      (arb),
        .Start_Timeout (tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first valid requester after the last grant, wrapping.
    function automatic int exp_win(input logic [NR-1:0] m, input int p);
        for (int k = 1; k <= NR; k++) begin
            if (m[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    task automatic chk_reset();
        check("rst_ack", 32'(ack), 0);
        check("rst_data", 32'(tx_data), 0);
        check("rst_start", 32'(start), 0);
        check("rst_gid", 32'(gid), NR - 1);
        check("rst_arb", 32'(arb), 0);
        check("rst_tmo", 32'(tmo), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        chk_reset();
        tick();
        rst   = 1'b0;
        ptr_m = NR - 1;
    endtask

    // One frame: optional blocked phase, grant, start handshake of d cycles
    // (d >= ST means the transmitter never answers), then L busy cycles.
    task automatic frame(input logic [NR-1:0] nmask, input logic [31:0] ndata,
                         input int blk, input int d, input int L);
        int w;
        logic [31:0] ed;
        if (blk > 0) begin
            tx_busy = 1'b1;
            repeat (blk) begin
                tick();
                check("blk_ack", 32'(ack), 0);
                check("blk_arb", 32'(arb), 0);
            end
            tx_busy = 1'b0;
        end
        w  = exp_win(req_valid, ptr_m);
        ed = (req_data >> (8 * w)) & 32'hFF;
        tick();
        check("gnt_ack", 32'(ack), 32'(1) << w);
        check("gnt_data", 32'(tx_data), ed);
        check("gnt_gid", 32'(gid), 32'(w));
        check("gnt_start", 32'(start), 1);
        check("gnt_arb", 32'(arb), 1);
        check("gnt_tmo", 32'(tmo), 0);
        ptr_m     = w;
        req_valid = nmask;
        req_data  = ndata;
        if (d >= ST) begin
            repeat (ST - 1) begin
                tick();
                check("to_start", 32'(start), 1);
                check("to_tmo", 32'(tmo), 0);
                check("to_ack", 32'(ack), 0);
            end
            tick();
            check("to_start_end", 32'(start), 0);
            check("to_pulse", 32'(tmo), 1);
            check("to_arb", 32'(arb), 0);
        end else begin
            repeat (d - 1) begin
                tick();
                check("st_start", 32'(start), 1);
                check("st_ack", 32'(ack), 0);
            end
            tx_busy = 1'b1;
            tick();
            check("st_fall", 32'(start), 0);
            check("bz_arb0", 32'(arb), 1);
            check("bz_ack", 32'(ack), 0);
            repeat (L - 1) begin
                tick();
                check("bz_arb", 32'(arb), 1);
                check("bz_start", 32'(start), 0);
            end
            tx_busy = 1'b0;
            tick();
            check("end_arb", 32'(arb), 0);
            check("end_tmo", 32'(tmo), 0);
        end
    endtask

    initial begin
        logic [NR-1:0] nm;
        int bl, dd, ll;
        rst       = 1'b0;
        tx_busy   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        ptr_m     = NR - 1;
        #2;
        do_reset();

        req_valid = 4'b0001;
        req_data  = 32'h0000_00A5;
        frame(4'b0000, 32'h0, 0, 2, 20);
        tick();
        check("idle_ack", 32'(ack), 0);
        check("idle_arb", 32'(arb), 0);

        do_reset();
        req_valid = 4'b1111;
        req_data  = 32'h1312_1110;
        repeat (4) frame(4'b1111, 32'h1312_1110, 0, 1, 3);
        frame(4'b0100, 32'h00C4_0000, 0, 2, 3);
        frame(4'b1001, 32'h5A00_00E1, 0, ST, 0);
        frame(4'b0010, 32'h0000_7700, 0, 3, 4);
        frame(4'b0000, 32'h0, 3, 1, 2);

        req_valid = 4'($urandom_range(1, 15));
        req_data  = $urandom;
        for (int i = 0; i < 150; i++) begin
            nm = 4'($urandom_range(1, 15));
            bl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            dd = ($urandom_range(0, 4) == 0) ? ST : $urandom_range(1, ST - 1);
            ll = $urandom_range(1, 5);
            frame(nm, $urandom, bl, dd, ll);
        end

        frame(4'b1000, 32'hEE00_0000, 0, 1, 2);
        tick();
        check("mid_ack", 32'(ack), 32'b1000);
        check("mid_gid", 32'(gid), 3);
        tx_busy = 1'b1;
        tick();
        tick();
        check("mid_arb", 32'(arb), 1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset();
        tick();
        rst       = 1'b0;
        ptr_m     = NR - 1;
        tx_busy   = 1'b0;
        req_valid = 4'b1001;
        req_data  = 32'h3300_0044;
        frame(4'b0000, 32'h0, 0, 2, 2);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
